mem_arbiter: RTL and testbench

- Two-master, one-slave arbiter that shares a single memory port between the CPU path (fabric RAM port, master 0) and the DMA engine (master 1).
- It lets the SoC use a single-port BRAM, or a single BRAM port, in place of the dual-port instance.
- Sits between mmio_fabric/dma_engine and the memory.
- Uses the standard req/we/addr/wdata/rdata/ready memory handshake on every side, with registered grant, round-robin or fixed priority, and a slave-timeout guard.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_rr2.sv | 37 +++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arbiter_rr2.sv
// Two-way round-robin picker with optional fixed priority; remembers the last
// grant so a tie goes to the master that was not served most recently.
module arb_rr2
  import mem_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant,
  output logic       valid
);

  logic last_grant;

  // Reset to master 1 so master 0 takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= ARB_M1;
    end else if (update) begin
      last_grant <= grant;
    end
  end

  always_comb begin
    valid = |req;
    grant = ARB_M0;
    unique case (req)
      2'b10:   grant = ARB_M1;
      2'b11:   grant = (FIXED_PRIO != 0) ? ARB_M0 : ~last_grant;
      default: grant = ARB_M0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the CPU path (master 0) and DMA (master 1),
// with a registered grant, optional round-robin and a slave-timeout guard.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                FIXED_PRIO     = 0,
  parameter int                TIMEOUT_CYCLES = 0,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = DATA_W'(ARB_TIMEOUT_RDATA)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_mem_req,
  input  logic              m0_mem_we,
  input  logic [ADDR_W-1:0] m0_mem_addr,
  input  logic [DATA_W-1:0] m0_mem_wdata,
  output logic [DATA_W-1:0] m0_mem_rdata,
  output logic              m0_mem_ready,
  input  logic              m1_mem_req,
  input  logic              m1_mem_we,
  input  logic [ADDR_W-1:0] m1_mem_addr,
  input  logic [DATA_W-1:0] m1_mem_wdata,
  output logic [DATA_W-1:0] m1_mem_rdata,
  output logic              m1_mem_ready,
  output logic              s_mem_req,
  output logic              s_mem_we,
  output logic [ADDR_W-1:0] s_mem_addr,
  output logic [DATA_W-1:0] s_mem_wdata,
  input  logic [DATA_W-1:0] s_mem_rdata,
  input  logic              s_mem_ready,
  output logic              timeout_err
);

  localparam bit          TMO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [31:0] TMO_LAST = TMO_EN ? 32'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_e        state, state_next;
  logic              winner;
  logic              pick_grant, pick_valid;
  logic              accept, finish, timed_out, timeout_hit;
  logic [31:0]       tcount;
  logic [DATA_W-1:0] resp_data;

  arb_rr2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_pick (
    .clk    (clk),
    .rst    (rst),
    .req    ({m1_mem_req, m0_mem_req}),
    .update (accept),
    .grant  (pick_grant),
    .valid  (pick_valid)
  );

  assign timeout_hit = TMO_EN && (tcount == TMO_LAST);
  assign resp_data   = finish ? s_mem_rdata : TIMEOUT_RDATA;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Requests are only looked at in IDLE; RESP gives the master a cycle to
  // drop or replace req before it can be accepted again.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    timed_out  = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          accept     = 1'b1;
          state_next = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (s_mem_ready) begin
          finish     = 1'b1;
          state_next = ARB_RESP;
        end else if (timeout_hit) begin
          timed_out  = 1'b1;
          state_next = ARB_RESP;
        end
      end
      ARB_RESP: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winner       <= ARB_M0;
      s_mem_req    <= 1'b0;
      s_mem_we     <= 1'b0;
      s_mem_addr   <= '0;
      s_mem_wdata  <= '0;
      m0_mem_rdata <= '0;
      m1_mem_rdata <= '0;
      m0_mem_ready <= 1'b0;
      m1_mem_ready <= 1'b0;
      timeout_err  <= 1'b0;
      tcount       <= '0;
    end else begin
      m0_mem_ready <= 1'b0;
      m1_mem_ready <= 1'b0;
      timeout_err  <= 1'b0;

      if (accept) begin
        winner      <= pick_grant;
        s_mem_req   <= 1'b1;
        s_mem_we    <= (pick_grant == ARB_M1) ? m1_mem_we    : m0_mem_we;
        s_mem_addr  <= (pick_grant == ARB_M1) ? m1_mem_addr  : m0_mem_addr;
        s_mem_wdata <= (pick_grant == ARB_M1) ? m1_mem_wdata : m0_mem_wdata;
        tcount      <= '0;
      end

      if (state == ARB_BUSY && !finish && !timed_out && TMO_EN) begin
        tcount <= tcount + 32'd1;
      end

      // Ready is registered so it lands in the RESP cycle together with rdata.
      if (finish || timed_out) begin
        s_mem_req   <= 1'b0;
        timeout_err <= timed_out;
        if (winner == ARB_M1) begin
          m1_mem_rdata <= resp_data;
          m1_mem_ready <= 1'b1;
        end else begin
          m0_mem_rdata <= resp_data;
          m0_mem_ready <= 1'b1;
        end
      end

      if (state == ARB_RESP) begin
        tcount <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: a round-robin/timeout instance and a fixed-priority instance
// share master stimulus, each with its own simple wait-state slave.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] slave_data;
  int unsigned wait_n;

  logic [31:0] m0_rdata [2];
  logic [31:0] m1_rdata [2];
  logic [31:0] s_addr   [2];
  logic [31:0] s_wdata  [2];
  logic [31:0] busy_cnt [2];
  logic        m0_ready [2];
  logic        m1_ready [2];
  logic        s_req    [2];
  logic        s_we     [2];
  logic        s_ready  [2];
  logic        terr     [2];
  logic        mute     [2];

  int n_cmp, n_err;
  int p0 [2];
  int bad_pulse;
  logic prev0 [2];
  logic prev1 [2];
  int saved_p0;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0), .TIMEOUT_CYCLES(8),
    .TIMEOUT_RDATA(32'hDEAD_BEEF)
  ) dut_rr (
    .clk(clk), .rst(rst),
    .m0_mem_req(m0_req), .m0_mem_we(m0_we), .m0_mem_addr(m0_addr),
    .m0_mem_wdata(m0_wdata), .m0_mem_rdata(m0_rdata[0]), .m0_mem_ready(m0_ready[0]),
    .m1_mem_req(m1_req), .m1_mem_we(m1_we), .m1_mem_addr(m1_addr),
    .m1_mem_wdata(m1_wdata), .m1_mem_rdata(m1_rdata[0]), .m1_mem_ready(m1_ready[0]),
    .s_mem_req(s_req[0]), .s_mem_we(s_we[0]), .s_mem_addr(s_addr[0]),
    .s_mem_wdata(s_wdata[0]), .s_mem_rdata(slave_data), .s_mem_ready(s_ready[0]),
    .timeout_err(terr[0])
  );

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1), .TIMEOUT_CYCLES(0),
    .TIMEOUT_RDATA(32'hDEAD_BEEF)
  ) dut_fp (
    .clk(clk), .rst(rst),
    .m0_mem_req(m0_req), .m0_mem_we(m0_we), .m0_mem_addr(m0_addr),
    .m0_mem_wdata(m0_wdata), .m0_mem_rdata(m0_rdata[1]), .m0_mem_ready(m0_ready[1]),
    .m1_mem_req(m1_req), .m1_mem_we(m1_we), .m1_mem_addr(m1_addr),
    .m1_mem_wdata(m1_wdata), .m1_mem_rdata(m1_rdata[1]), .m1_mem_ready(m1_ready[1]),
    .s_mem_req(s_req[1]), .s_mem_we(s_we[1]), .s_mem_addr(s_addr[1]),
    .s_mem_wdata(s_wdata[1]), .s_mem_rdata(slave_data), .s_mem_ready(s_ready[1]),
    .timeout_err(terr[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slave answers after wait_n wait states unless muted.
  for (genvar g = 0; g < 2; g++) begin : g_slave
    assign s_ready[g] = s_req[g] && !mute[g] && (busy_cnt[g] == wait_n);
    always @(posedge clk or posedge rst) begin
      if (rst) busy_cnt[g] <= '0;
      else if (!s_req[g] || s_ready[g]) busy_cnt[g] <= '0;
      else busy_cnt[g] <= busy_cnt[g] + 32'd1;
    end
  end

  // Ready must be a single-cycle pulse and never given to both masters.
  initial begin
    bad_pulse = 0;
    p0[0] = 0; p0[1] = 0;
    prev0[0] = 1'b0; prev0[1] = 1'b0; prev1[0] = 1'b0; prev1[1] = 1'b0;
  end
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (m0_ready[d]) p0[d]++;
      if ((m0_ready[d] && prev0[d]) || (m1_ready[d] && prev1[d]) ||
          (m0_ready[d] && m1_ready[d])) bad_pulse++;
      prev0[d] = m0_ready[d];
      prev1[d] = m1_ready[d];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    slave_data = '0; wait_n = 0; mute[0] = 1'b0; mute[1] = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("rst_s_req", s_req[d], 0);
      check("rst_m0_ready", m0_ready[d], 0);
      check("rst_m1_ready", m1_ready[d], 0);
      check("rst_terr", terr[d], 0);
      check("rst_s_addr", s_addr[d], 0);
      check("rst_m0_rdata", m0_rdata[d], 0);
    end
    rst = 1'b0;

    // Both masters hold req from reset: rr alternates, fp always picks m0.
    m0_addr = 32'h10; m1_addr = 32'h20;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      slave_data = 32'h1000_0000 + 32'(i);
      tick();
      check("rr_s_addr", s_addr[0], (i % 2 == 1) ? 32'h20 : 32'h10);
      check("fp_s_addr", s_addr[1], 32'h10);
      check("rr_s_req", s_req[0], 1);
      tick();
      check("rr_m0_ready", m0_ready[0], (i % 2 == 0) ? 1 : 0);
      check("rr_m1_ready", m1_ready[0], (i % 2 == 1) ? 1 : 0);
      check("rr_rdata", (i % 2 == 1) ? m1_rdata[0] : m0_rdata[0], 32'h1000_0000 + 32'(i));
      check("fp_m0_ready", m0_ready[1], 1);
      check("fp_m1_ready", m1_ready[1], 0);
      if (i == 3) m0_req = 1'b0;
      tick();
      check("rr_ready_single", {m0_ready[0], m1_ready[0]}, 0);
    end
    tick();
    check("drop_rr_s_addr", s_addr[0], 32'h20);
    check("drop_fp_s_addr", s_addr[1], 32'h20);
    tick();
    check("drop_rr_m1_ready", m1_ready[0], 1);
    check("drop_fp_m1_ready", m1_ready[1], 1);
    m1_req = 1'b0;
    tick();

    // Single zero-wait read.
    m0_addr = 32'h100; m0_we = 1'b0; slave_data = 32'h1234_5678; m0_req = 1'b1;
    tick();
    check("rd_s_addr", s_addr[0], 32'h100);
    check("rd_s_req", s_req[0], 1);
    check("rd_early_ready", m0_ready[0], 0);
    tick();
    check("rd_m0_ready", m0_ready[0], 1);
    check("rd_m0_rdata", m0_rdata[0], 32'h1234_5678);
    check("rd_m1_ready", m1_ready[0], 0);
    check("rd_s_req_drop", s_req[0], 0);
    m0_req = 1'b0;
    tick();
    check("rd_ready_end", m0_ready[0], 0);

    // m1 write with five wait states; master changes fields after grant.
    wait_n = 5; slave_data = 32'h0BAD_0001;
    m1_we = 1'b1; m1_addr = 32'h200; m1_wdata = 32'hCAFE_F00D; m1_req = 1'b1;
    tick();
    m1_addr = 32'h300; m1_wdata = 32'h1111_1111; m1_we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("wr_s_req", s_req[0], 1);
      check("wr_s_we", s_we[0], 1);
      check("wr_s_addr", s_addr[0], 32'h200);
      check("wr_s_wdata", s_wdata[0], 32'hCAFE_F00D);
      check("wr_m1_early", m1_ready[0], 0);
      tick();
    end
    check("wr_m1_ready", m1_ready[0], 1);
    check("wr_m1_rdata", m1_rdata[0], 32'h0BAD_0001);
    check("wr_s_req_drop", s_req[0], 0);
    m1_req = 1'b0; wait_n = 0;
    tick();
    check("wr_ready_end", m1_ready[0], 0);

    // Slave never answers the rr instance: forced completion after 8 BUSY cycles.
    mute[0] = 1'b1; m0_addr = 32'h400; m0_req = 1'b1;
    tick();
    check("to_s_req_rise", s_req[0], 1);
    for (int k = 0; k < 7; k++) begin
      tick();
      check("to_s_req_held", s_req[0], 1);
      check("to_no_ready", m0_ready[0], 0);
      check("to_no_err", terr[0], 0);
    end
    tick();
    check("to_m0_ready", m0_ready[0], 1);
    check("to_err", terr[0], 1);
    check("to_rdata", m0_rdata[0], 32'hDEAD_BEEF);
    check("to_s_req_drop", s_req[0], 0);
    m0_req = 1'b0; mute[0] = 1'b0;
    tick();
    check("to_err_end", terr[0], 0);
    check("to_ready_end", m0_ready[0], 0);

    m0_addr = 32'h500; slave_data = 32'h55AA_55AA; m0_req = 1'b1;
    tick();
    check("post_to_s_addr", s_addr[0], 32'h500);
    tick();
    check("post_to_ready", m0_ready[0], 1);
    check("post_to_rdata", m0_rdata[0], 32'h55AA_55AA);
    check("post_to_err", terr[0], 0);
    m0_req = 1'b0;
    tick();

    // Reset while BUSY: outputs clear at once, abandoned access never completes.
    wait_n = 3; m0_addr = 32'h600; m0_req = 1'b1;
    tick();
    tick();
    check("mid_busy", s_req[0], 1);
    rst = 1'b1;
    #1;
    check("mid_rst_s_req", s_req[0], 0);
    check("mid_rst_s_addr", s_addr[0], 0);
    check("mid_rst_m0_rdata", m0_rdata[0], 0);
    check("mid_rst_m0_ready", m0_ready[0], 0);
    check("mid_rst_terr", terr[0], 0);
    m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'h700; wait_n = 0;
    saved_p0 = p0[0];
    #1 rst = 1'b0;
    tick();
    check("mid_m1_s_addr", s_addr[0], 32'h700);
    tick();
    check("mid_m1_ready", m1_ready[0], 1);
    m1_req = 1'b0;
    tick();
    tick();
    check("mid_no_m0_ready", p0[0] - saved_p0, 0);

    // After reset a tie goes to m0 even though m1 was served last.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_addr = 32'h10; m1_addr = 32'h20; m0_req = 1'b1; m1_req = 1'b1;
    tick();
    check("tie_after_rst", s_addr[0], 32'h10);
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (4) tick();

    check("single_pulse", bad_pulse, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
